// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column rotation, press/release debounce, one event per press,
// two-digit history. Defining KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 10_000_000
`endif
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_l,
    output logic [3:0] digit_r,
    output logic [1:0] state_dbg
);

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       ROWS_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       rows_meta_q, rows_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       row_pat_q, row_pat_d;
    logic [3:0]       key_code_q, digit_l_q, digit_r_q;
    logic             key_valid_q;
    logic             emit;
    logic [3:0]       emit_code;
    logic             rows_idle, rows_match, scan_last, deb_last;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // Lowest-index low row wins when several rows are pulled down together.
    function automatic logic [3:0] key_lookup(input logic [3:0] pat, input logic [1:0] col);
        logic [1:0] row;
        logic [3:0] code;
        if (!pat[0])      row = 2'd0;
        else if (!pat[1]) row = 2'd1;
        else if (!pat[2]) row = 2'd2;
        else              row = 2'd3;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            rows_meta_q <= ROWS_IDLE;
            rows_s_q    <= ROWS_IDLE;
        end else begin
            rows_meta_q <= rows;
            rows_s_q    <= rows_meta_q;
        end
    end

    assign rows_idle  = (rows_s_q == ROWS_IDLE);
    assign rows_match = (rows_s_q == row_pat_q);
    assign scan_last  = (cnt_q == SCAN_LAST);
    assign deb_last   = (cnt_q == DEB_LAST);

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) state_q <= ST_SCAN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN:     if (scan_last && !rows_idle) state_d = ST_DEBOUNCE;
            ST_DEBOUNCE: begin
                if (!rows_match)   state_d = ST_SCAN;
                else if (deb_last) state_d = ST_HELD;
            end
            ST_HELD:     if (rows_idle) state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (!rows_idle)    state_d = ST_HELD;
                else if (deb_last) state_d = ST_SCAN;
            end
            default:     state_d = ST_SCAN;
        endcase
    end

    // Counter is cleared on every state change, so each state counts from zero.
    always_comb begin
        cnt_d     = cnt_q;
        col_idx_d = col_idx_q;
        row_pat_d = row_pat_q;
        emit      = 1'b0;
        emit_code = key_lookup(row_pat_q, col_idx_q);
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d = '0;
`endif
        case (state_q)
            ST_SCAN: begin
                if (scan_last) begin
                    cnt_d = '0;
                    if (!rows_idle) row_pat_d = rows_s_q;
                    else            col_idx_d = col_idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (!rows_match) begin
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                end else if (deb_last) begin
                    cnt_d = '0;
                    emit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                if (!rows_idle) begin
                    if (rep_cnt_q == REP_LAST) begin
                        emit      = 1'b1;
                        emit_code = key_code_q;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
`endif
            end
            ST_RELEASE: begin
                if (!rows_idle) begin
                    cnt_d = '0;
                end else if (deb_last) begin
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            row_pat_q   <= ROWS_IDLE;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            digit_l_q   <= 4'h0;
            digit_r_q   <= 4'h0;
        end else begin
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            row_pat_q   <= row_pat_d;
            key_valid_q <= emit;
            if (emit) begin
                key_code_q <= emit_code;
                digit_l_q  <= digit_r_q;
                digit_r_q  <= emit_code;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) rep_cnt_q <= '0;
        else       rep_cnt_q <= rep_cnt_d;
    end
`endif

    assign cols      = ~(4'b0001 << col_idx_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign digit_l   = digit_l_q;
    assign digit_r   = digit_r_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 key matrix driving the rows.
module tb_keypad_scan_ctrl;

    localparam int SCAN_CYCLES     = 4;
    localparam int DEBOUNCE_CYCLES = 8;
`ifdef KEYPAD_REPEAT_EN
    localparam int REPEAT_CYCLES   = 50;
`endif
    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic        int_osc = 1'b0;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  digit_l;
    logic [3:0]  digit_r;
    logic [1:0]  state_dbg;
    logic [15:0] press;      // bit row*4+col = key held down

    int n_cmp = 0;
    int n_err = 0;
    int kv_count = 0;

    keypad_scan_ctrl #(
        .SCAN_CYCLES(SCAN_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) dut (
        .int_osc(int_osc),
        .reset(reset),
        .rows(rows),
        .cols(cols),
        .key_valid(key_valid),
        .key_code(key_code),
        .digit_l(digit_l),
        .digit_r(digit_r),
        .state_dbg(state_dbg)
    );

    always #5 int_osc = ~int_osc;

    // A pressed key shorts its row to its column; undriven rows float high.
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(posedge int_osc) begin
        #2;
        if (key_valid === 1'b1) kv_count++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge int_osc);
    endtask

    task automatic wait_state(input logic [1:0] s, input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge int_osc);
            if (state_dbg === s) seen = 1'b1;
        end
    endtask

    task automatic wait_event(input int base, input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge int_osc);
            if (kv_count != base) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        press = '0;
        #2;
        n_cmp++;
        if ({cols, key_valid, key_code, digit_l, digit_r} !== {4'b1110, 1'b0, 12'h000}) begin
            n_err++;
            $display("FAIL reset_values: got cols=%b kv=%b code=%h dl=%h dr=%h want 1110 0 0 0 0",
                     cols, key_valid, key_code, digit_l, digit_r);
        end
        cyc(2);
        reset = 1'b0;
        cyc(3);
        n_cmp++;
        if (cols !== 4'b1110) begin
            n_err++;
            $display("FAIL scan_dwell: got cols=%b want 1110", cols);
        end
        cyc(1);
        n_cmp++;
        if (cols !== 4'b1101) begin
            n_err++;
            $display("FAIL scan_advance: got cols=%b want 1101", cols);
        end
        cyc(2);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({cols, state_dbg} !== {4'b1110, ST_SCAN}) begin
            n_err++;
            $display("FAIL async_reset: got cols=%b state=%0d want 1110 0", cols, state_dbg);
        end
        @(negedge int_osc);
        reset = 1'b0;
    endtask

    task automatic test_first_key;
        int base;
        bit seen;
        base = kv_count;
        press[1*4+0] = 1'b1;
        wait_event(base, 30, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL key4_latency: got no event want event within 30 cycles");
        end
        cyc(20);
        n_cmp++;
        if (kv_count - base != 1) begin
            n_err++;
            $display("FAIL key4_count: got %0d want 1", kv_count - base);
        end
        n_cmp++;
        if ({key_code, digit_l, digit_r} !== 12'h404) begin
            n_err++;
            $display("FAIL key4_value: got code=%h dl=%h dr=%h want 4 0 4", key_code, digit_l, digit_r);
        end
        n_cmp++;
        if (state_dbg !== ST_HELD) begin
            n_err++;
            $display("FAIL key4_held: got state=%0d want %0d", state_dbg, ST_HELD);
        end
        press = '0;
        cyc(20);
        n_cmp++;
        if (kv_count - base != 1 || state_dbg !== ST_SCAN) begin
            n_err++;
            $display("FAIL key4_release: got count=%0d state=%0d want 1 0", kv_count - base, state_dbg);
        end
    endtask

    task automatic test_second_key;
        int base;
        bit seen;
        base = kv_count;
        press[2*4+2] = 1'b1;
        wait_event(base, 40, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL key9_event: got no event want event within 40 cycles");
        end
        cyc(20);
        press = '0;
        cyc(20);
        n_cmp++;
        if (kv_count - base != 1) begin
            n_err++;
            $display("FAIL key9_count: got %0d want 1", kv_count - base);
        end
        n_cmp++;
        if ({key_code, digit_l, digit_r} !== 12'h949) begin
            n_err++;
            $display("FAIL key9_value: got code=%h dl=%h dr=%h want 9 4 9", key_code, digit_l, digit_r);
        end
    endtask

    task automatic test_bounce;
        int base;
        bit seen;
        base = kv_count;
        press[3*4+0] = 1'b1;
        wait_state(ST_DEBOUNCE, 40, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL bounce_debounce: got no DEBOUNCE state want DEBOUNCE within 40 cycles");
        end
        cyc(1);
        press = '0;
        wait_state(ST_SCAN, 8, seen);
        n_cmp++;
        if (!seen || cols !== 4'b1101) begin
            n_err++;
            $display("FAIL bounce_rescan: got seen=%0d cols=%b want 1 1101", seen, cols);
        end
        cyc(30);
        n_cmp++;
        if (kv_count != base) begin
            n_err++;
            $display("FAIL bounce_no_event: got %0d events want 0", kv_count - base);
        end
    endtask

    task automatic test_hold_long;
        int base;
        int exp_n;
        logic [3:0] exp_dl;
        bit seen;
        base = kv_count;
`ifdef KEYPAD_REPEAT_EN
        exp_n  = 4;
        exp_dl = 4'h0;
`else
        exp_n  = 1;
        exp_dl = 4'h9;
`endif
        press[3*4+1] = 1'b1;
        wait_event(base, 40, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL hold_event: got no event want event within 40 cycles");
        end
        cyc(170);
        press = '0;
        cyc(20);
        n_cmp++;
        if (kv_count - base != exp_n) begin
            n_err++;
            $display("FAIL hold_count: got %0d want %0d", kv_count - base, exp_n);
        end
        n_cmp++;
        if ({key_code, digit_l, digit_r} !== {4'h0, exp_dl, 4'h0}) begin
            n_err++;
            $display("FAIL hold_value: got code=%h dl=%h dr=%h want 0 %h 0", key_code, digit_l, digit_r, exp_dl);
        end
    endtask

    task automatic test_two_keys;
        int base;
        bit seen;
        bit saw_held;
        base = kv_count;
        press[0*4+0] = 1'b1;
        press[1*4+0] = 1'b1;
        wait_event(base, 40, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL twokey_event: got no event want event within 40 cycles");
        end
        cyc(5);
        n_cmp++;
        if ({key_code, digit_l, digit_r} !== 12'h101) begin
            n_err++;
            $display("FAIL twokey_value: got code=%h dl=%h dr=%h want 1 0 1", key_code, digit_l, digit_r);
        end
        press = '0;
        wait_state(ST_RELEASE, 10, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL twokey_release: got no RELEASE state want RELEASE within 10 cycles");
        end
        cyc(2);
        press[0*4+0] = 1'b1;
        saw_held = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (i == 1) press = '0;
            if (state_dbg === ST_HELD) saw_held = 1'b1;
        end
        n_cmp++;
        if (!saw_held) begin
            n_err++;
            $display("FAIL glitch_held: got no return to HELD want HELD");
        end
        wait_state(ST_SCAN, 30, seen);
        n_cmp++;
        if (!seen || cols !== 4'b1101) begin
            n_err++;
            $display("FAIL twokey_rescan: got seen=%0d cols=%b want 1 1101", seen, cols);
        end
        n_cmp++;
        if (kv_count - base != 1) begin
            n_err++;
            $display("FAIL glitch_count: got %0d want 1", kv_count - base);
        end
    endtask

    task automatic test_reset_mid_debounce;
        int base;
        bit seen;
        base = kv_count;
        press[0*4+1] = 1'b1;
        wait_state(ST_DEBOUNCE, 40, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL rstdeb_enter: got no DEBOUNCE state want DEBOUNCE within 40 cycles");
        end
        cyc(2);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({cols, key_valid, key_code, digit_l, digit_r, state_dbg} !== {4'b1110, 1'b0, 12'h000, ST_SCAN}) begin
            n_err++;
            $display("FAIL rstdeb_values: got cols=%b kv=%b code=%h dl=%h dr=%h state=%0d want 1110 0 0 0 0 0",
                     cols, key_valid, key_code, digit_l, digit_r, state_dbg);
        end
        press = '0;
        cyc(2);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (cols !== 4'b1110) begin
            n_err++;
            $display("FAIL rstdeb_col0: got cols=%b want 1110", cols);
        end
        cyc(30);
        n_cmp++;
        if (kv_count != base || {digit_l, digit_r} !== 8'h00) begin
            n_err++;
            $display("FAIL rstdeb_no_event: got events=%0d dl=%h dr=%h want 0 0 0", kv_count - base, digit_l, digit_r);
        end
    endtask

    initial begin
        test_reset();
        test_first_key();
        test_second_key();
        test_bounce();
        test_hold_long();
        test_two_keys();
        test_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
